// File: rtl/qucs_record_emitter.sv
`default_nettype none
// ============================================================================
// Module      : qucs_record_emitter
// Description : Serialises one lumped-component record (R, C, L, Gyrator,
//               Amp) into a qucsator-style netlist line, one ASCII byte per
//               accepted transfer on the tx stream.
// Revision    : 1.0  initial release
// ============================================================================
module qucs_record_emitter #(
    parameter int NODE_W = 8,
    parameter int VAL_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rec_valid,
    output logic                rec_ready,
    input  logic [2:0]          rec_type,
    input  logic [7:0]          rec_inst,
    input  logic [4*NODE_W-1:0] rec_node,
    input  logic [VAL_W-1:0]    rec_val,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_last,
    output logic                err_type
);

    localparam int c_ND    = NODE_W / 4;
    localparam int c_VD    = VAL_W / 4;
    localparam int c_IDX_W = $clog2(c_ND + c_VD + 8);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NAME    = 3'd1,
        S_COLON_X = 3'd2,
        S_INST    = 3'd3,
        S_NODE    = 3'd4,
        S_PNAME   = 3'd5,
        S_VALUE   = 3'd6,
        S_NL      = 3'd7
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [1:0]          r_sel;
    logic [2:0]          r_type;
    logic [7:0]          r_inst;
    logic [4*NODE_W-1:0] r_nodes;
    logic [VAL_W-1:0]    r_val;
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
    logic                r_tx_last;
    logic                r_err;

    logic [NODE_W-1:0]   w_node_arr [4];
    logic [NODE_W-1:0]   w_cur_node;
    logic [NODE_W-1:0]   w_nxt_node;
    state_t              w_nxt_state;
    logic [c_IDX_W-1:0]  w_nxt_idx;
    logic [1:0]          w_nxt_sel;
    logic [7:0]          w_nxt_byte;
    logic                w_accept;
    logic                w_xfer;
    logic                w_type_ok;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_node
            assign w_node_arr[k] = r_nodes[k*NODE_W +: NODE_W];
        end
    endgenerate

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] name_char(input logic [2:0] typ, input int i);
        logic [7:0] ch;
        ch = 8'h3F;
        case (typ)
            3'd0: ch = "R";
            3'd1: ch = "C";
            3'd2: ch = "L";
            3'd3: begin
                case (i)
                    0:       ch = "G";
                    1:       ch = "y";
                    2:       ch = "r";
                    3:       ch = "a";
                    4:       ch = "t";
                    5:       ch = "o";
                    default: ch = "r";
                endcase
            end
            3'd4: ch = (i == 0) ? "A" : (i == 1) ? "m" : "p";
            default: ch = 8'h3F;
        endcase
        return ch;
    endfunction

    function automatic int name_len(input logic [2:0] typ);
        return (typ == 3'd3) ? 7 : (typ == 3'd4) ? 3 : 1;
    endfunction

    function automatic int node_count(input logic [2:0] typ);
        return (typ == 3'd3) ? 4 : 2;
    endfunction

    // Parameter letter: Gyrator is parameterised by R, Amp by gain G
    function automatic logic [7:0] p_char(input logic [2:0] typ);
        logic [7:0] ch;
        case (typ)
            3'd1:    ch = "C";
            3'd2:    ch = "L";
            3'd4:    ch = "G";
            default: ch = "R";
        endcase
        return ch;
    endfunction

    function automatic int seg_len(input state_t st, input logic [2:0] typ,
                                   input logic [NODE_W-1:0] nd);
        int n;
        case (st)
            S_NAME:    n = name_len(typ);
            S_COLON_X: n = 2;
            S_INST:    n = 2;
            S_NODE:    n = (nd == '0) ? 4 : 3 + c_ND;
            S_PNAME:   n = 3;
            S_VALUE:   n = c_VD + 4;
            default:   n = 1;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] byte_at(input state_t st, input int i,
                                           input logic [2:0] typ, input logic [7:0] inst,
                                           input logic [NODE_W-1:0] nd,
                                           input logic [VAL_W-1:0] val);
        logic [7:0] b;
        case (st)
            S_NAME:    b = name_char(typ, i);
            S_COLON_X: b = (i == 0) ? ":" : "X";
            S_INST:    b = hex_char((i == 0) ? inst[7:4] : inst[3:0]);
            S_NODE: begin
                if (i == 0)
                    b = " ";
                else if (nd == '0)
                    b = (i == 1) ? "g" : (i == 2) ? "n" : "d";
                else
                    b = (i == 1) ? "_" : (i == 2) ? "n"
                      : hex_char(4'(nd >> (4 * (c_ND + 2 - i))));
            end
            S_PNAME:   b = (i == 0) ? " " : (i == 1) ? p_char(typ) : "=";
            S_VALUE: begin
                if (i == 0 || i == c_VD + 3)
                    b = 8'h22;
                else
                    b = (i == 1) ? "0" : (i == 2) ? "x"
                      : hex_char(4'(val >> (4 * (c_VD + 2 - i))));
            end
            S_NL:      b = 8'h0A;
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

    assign rec_ready = (r_state == S_IDLE);
    assign w_accept  = rec_valid && rec_ready;
    assign w_xfer    = r_tx_valid && tx_ready;
    assign w_type_ok = (rec_type <= 3'd4);
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign tx_last   = r_tx_last;
    assign err_type  = r_err;

    // Position of the byte that follows the one currently on tx_data
    always_comb begin
        w_cur_node  = w_node_arr[r_sel];
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx + 1'b1;
        w_nxt_sel   = r_sel;
        if (int'(r_idx) == seg_len(r_state, r_type, w_cur_node) - 1) begin
            w_nxt_idx = '0;
            case (r_state)
                S_NAME:    w_nxt_state = S_COLON_X;
                S_COLON_X: w_nxt_state = S_INST;
                S_INST:    w_nxt_state = S_NODE;
                S_NODE: begin
                    if (int'(r_sel) == node_count(r_type) - 1) begin
                        w_nxt_state = S_PNAME;
                        w_nxt_sel   = '0;
                    end else begin
                        w_nxt_sel   = r_sel + 1'b1;
                    end
                end
                S_PNAME:   w_nxt_state = S_VALUE;
                S_VALUE:   w_nxt_state = S_NL;
                default:   w_nxt_state = S_IDLE;
            endcase
        end
        w_nxt_node = w_node_arr[w_nxt_sel];
        w_nxt_byte = byte_at(w_nxt_state, int'(w_nxt_idx), r_type, r_inst, w_nxt_node, r_val);
    end

    // Record capture, line sequencing and registered tx/err outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_sel      <= '0;
            r_type     <= '0;
            r_inst     <= '0;
            r_nodes    <= '0;
            r_val      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_last  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_type  <= rec_type;
                r_inst  <= rec_inst;
                r_nodes <= rec_node;
                r_val   <= rec_val;
                r_idx   <= '0;
                r_sel   <= '0;
                if (w_type_ok) begin
                    // First name character comes straight from the input type
                    r_state    <= S_NAME;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= name_char(rec_type, 0);
                    r_tx_last  <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_xfer) begin
                if (r_state == S_NL) begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= '0;
                    r_tx_last  <= 1'b0;
                end else begin
                    r_state   <= w_nxt_state;
                    r_idx     <= w_nxt_idx;
                    r_sel     <= w_nxt_sel;
                    r_tx_data <= w_nxt_byte;
                    r_tx_last <= (w_nxt_state == S_NL);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qucs_record_emitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_qucs_record_emitter
// Description : Directed, table-driven bench for qucs_record_emitter with
//               hand-written sequences for reset mid-line and back-to-back.
// Revision    : 1.0  initial release
// ============================================================================
module tb_qucs_record_emitter;

    localparam int NODE_W = 8;
    localparam int VAL_W  = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                rec_valid = 1'b0;
    logic                rec_ready;
    logic [2:0]          rec_type = '0;
    logic [7:0]          rec_inst = '0;
    logic [4*NODE_W-1:0] rec_node = '0;
    logic [VAL_W-1:0]    rec_val = '0;
    logic                tx_valid;
    logic                tx_ready = 1'b1;
    logic [7:0]          tx_data;
    logic                tx_last;
    logic                err_type;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  typ;
        logic [7:0]  inst;
        logic [31:0] nodes;
        logic [31:0] val;
        int          ready_mode;
        bit          exp_err;
    } vec_t;

    vec_t  vecs [7];
    string exp_text [7];

    qucs_record_emitter #(.NODE_W(NODE_W), .VAL_W(VAL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_type  (rec_type),
        .rec_inst  (rec_inst),
        .rec_node  (rec_node),
        .rec_val   (rec_val),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .err_type  (err_type)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s: got 0x%0h need 0x%0h", name, got, need);
        end
    endtask

    // Offer one record, then collect and verify its line (or error pulse)
    task automatic run_line(input string tag, input vec_t v, input string line_exp,
                            input bit hold, input vec_t nxt, output int waited);
        int         w;
        int         cyc;
        int         last_err;
        int         stab_err;
        int         busy_err;
        int         mism;
        int         first;
        bit         done;
        bit         prev_stall;
        bit         any_valid;
        bit         bad_ready;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [7:0] got [$];

        rec_valid = 1'b1;
        rec_type  = v.typ;
        rec_inst  = v.inst;
        rec_node  = v.nodes;
        rec_val   = v.val;
        w = 0;
        while (!rec_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        waited = w;
        if (!rec_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept: rec_ready never rose", tag);
            rec_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold) begin
            rec_type = nxt.typ;
            rec_inst = nxt.inst;
            rec_node = nxt.nodes;
            rec_val  = nxt.val;
        end else begin
            rec_valid = 1'b0;
            rec_type  = 3'($urandom);
            rec_inst  = 8'($urandom);
            rec_node  = $urandom;
            rec_val   = $urandom;
        end

        if (v.exp_err) begin
            check({tag, " err_pulse"}, 64'({err_type, tx_valid}), 64'd2);
            any_valid = 1'b0;
            bad_ready = 1'b0;
            @(negedge clk);
            check({tag, " err_clear"}, 64'(err_type), 64'd0);
            repeat (3) begin
                if (tx_valid)   any_valid = 1'b1;
                if (!rec_ready) bad_ready = 1'b1;
                @(negedge clk);
            end
            check({tag, " err_no_tx"}, 64'(any_valid), 64'd0);
            check({tag, " err_ready"}, 64'(bad_ready), 64'd0);
            return;
        end

        check({tag, " first_byte_latency"}, 64'({err_type, tx_valid}), 64'd1);
        done = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        last_err = 0;
        stab_err = 0;
        busy_err = 0;
        cyc = 0;
        while (!done && cyc < 400) begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data || tx_last !== prev_last))
                stab_err++;
            if (hold && rec_ready)
                busy_err++;
            tx_ready = (v.ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (tx_valid && tx_ready) begin
                if (tx_last !== (got.size() == line_exp.len() - 1))
                    last_err++;
                got.push_back(tx_data);
                if (tx_last) done = 1'b1;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b1;

        check({tag, " completed"}, 64'(done), 64'd1);
        check({tag, " length"}, 64'(got.size()), 64'(line_exp.len()));
        mism = 0;
        first = 0;
        for (int i = 0; i < got.size() && i < line_exp.len(); i++) begin
            if (got[i] !== 8'(line_exp[i])) begin
                if (mism == 0) first = i;
                mism++;
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL %s bytes: %0d wrong, first at %0d got 0x%02h need 0x%02h",
                     tag, mism, first, got[first], 8'(line_exp[first]));
        end
        check({tag, " tx_last_pos"}, 64'(last_err), 64'd0);
        check({tag, " stall_stable"}, 64'(stab_err), 64'd0);
        if (hold)
            check({tag, " busy_no_ready"}, 64'(busy_err), 64'd0);
        check({tag, " idle_after"}, 64'({rec_ready, tx_valid}), 64'd2);
    endtask

    vec_t l_vec;
    vec_t b2b_a;
    vec_t b2b_b;
    int   waited;

    initial begin
        vecs[0] = '{3'd0, 8'h05, 32'h0000_0003, 32'h0000_0032, 0, 1'b0};
        exp_text[0] = "R:X05 _n03 gnd R=\"0x00000032\"\n";
        vecs[1] = '{3'd3, 8'h01, 32'h0000_0201, 32'd50, 0, 1'b0};
        exp_text[1] = "Gyrator:X01 _n01 _n02 gnd gnd R=\"0x00000032\"\n";
        vecs[2] = '{3'd4, 8'h02, 32'h0000_0201, 32'd10, 1, 1'b0};
        exp_text[2] = "Amp:X02 _n01 _n02 G=\"0x0000000A\"\n";
        vecs[3] = '{3'd6, 8'h33, 32'h0000_0101, 32'h1, 0, 1'b1};
        exp_text[3] = "";
        vecs[4] = '{3'd1, 8'h7E, 32'h0000_10FF, 32'hDEAD_BEEF, 0, 1'b0};
        exp_text[4] = "C:X7E _nFF _n10 C=\"0xDEADBEEF\"\n";
        vecs[5] = '{3'd2, 8'hA3, 32'h0000_0000, 32'h0000_0000, 1, 1'b0};
        exp_text[5] = "L:XA3 gnd gnd L=\"0x00000000\"\n";
        vecs[6] = '{3'd0, 8'hFF, 32'h6655_B00A, 32'h1234_5678, 0, 1'b0};
        exp_text[6] = "R:XFF _n0A _nB0 R=\"0x12345678\"\n";

        l_vec = '{3'd2, 8'h11, 32'h0000_0504, 32'h0000_CAFE, 0, 1'b0};
        b2b_a = '{3'd4, 8'h09, 32'h0000_0007, 32'h0000_0100, 1, 1'b0};
        b2b_b = '{3'd1, 8'h42, 32'h0000_0001, 32'h0000_0001, 0, 1'b0};

        #12;
        check("reset_flags", 64'({tx_valid, tx_last, err_type, rec_ready}), 64'd1);
        check("reset_data", 64'(tx_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_line($sformatf("vec%0d", i), vecs[i], exp_text[i], 1'b0, vecs[i], waited);

        // Reset asserted after the 10th byte of an L line
        rec_valid = 1'b1;
        rec_type  = l_vec.typ;
        rec_inst  = l_vec.inst;
        rec_node  = l_vec.nodes;
        rec_val   = l_vec.val;
        @(negedge clk);
        rec_valid = 1'b0;
        tx_ready  = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midline_rst_async", 64'({tx_valid, tx_last, rec_ready}), 64'd1);
        check("midline_rst_data", 64'(tx_data), 64'd0);
        @(negedge clk);
        check("midline_rst_hold", 64'(tx_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(rec_ready), 64'd1);
        run_line("after_rst", l_vec, "L:X11 _n04 _n05 L=\"0x0000CAFE\"\n", 1'b0, l_vec, waited);

        // Second record held valid throughout the first line
        run_line("b2b_first", b2b_a, "Amp:X09 _n07 gnd G=\"0x00000100\"\n", 1'b1, b2b_b, waited);
        run_line("b2b_second", b2b_b, "C:X42 _n01 gnd C=\"0x00000001\"\n", 1'b0, b2b_b, waited);
        check("b2b_gap", 64'(waited), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
